// File: rtl/hilo_pkg.sv
// Shared types and constants for the HI/LO sequencing unit.
package hilo_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    ISSUE     = 2'd1,
    MULT_WAIT = 2'd2,
    DIV_WAIT  = 2'd3
  } hilo_state_t;

  typedef enum logic [1:0] {
    OP_MULT = 2'd0,
    OP_MADD = 2'd1,
    OP_DIV  = 2'd2
  } hilo_op_t;

  // Cycles from the start pulse until the mult unit raises MultDone.
  localparam int MULT_LATENCY = 33;

endpackage

// File: rtl/hilo_unit_if.sv
// Control, mult/div handshake and architectural result signals of hilo_unit.
interface hilo_unit_if;

  logic        MultStart;
  logic        DivStart;
  logic        MaddStart;
  logic        MthiWr;
  logic        MtloWr;
  logic [31:0] RegAOut;
  logic        MultDone;
  logic [31:0] MultHI;
  logic [31:0] MultLO;
  logic        DivDone;
  logic [31:0] DivHI;
  logic [31:0] DivLO;
  logic        DivZero;
  logic        MultCtrl;
  logic        DivCtrl;
  logic [31:0] HI;
  logic [31:0] LO;
  logic        HiLoBusy;
  logic        DivZeroExc;
  logic        Timeout;

  modport master (
    output MultStart, DivStart, MaddStart, MthiWr, MtloWr, RegAOut,
    output MultDone, MultHI, MultLO, DivDone, DivHI, DivLO, DivZero,
    input  MultCtrl, DivCtrl, HI, LO, HiLoBusy, DivZeroExc, Timeout
  );

  modport slave (
    input  MultStart, DivStart, MaddStart, MthiWr, MtloWr, RegAOut,
    input  MultDone, MultHI, MultLO, DivDone, DivHI, DivLO, DivZero,
    output MultCtrl, DivCtrl, HI, LO, HiLoBusy, DivZeroExc, Timeout
  );

endinterface

// File: rtl/hilo_unit.sv
// HI/LO owner: sequences one mult/div at a time, serves MTHI/MTLO, stalls while busy.
// Optional multiply-accumulate is enabled by defining HILO_MADD_EN.
module hilo_unit
  import hilo_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 40,
  parameter int CNT_W          = 6
) (
  input logic       clk,
  input logic       reset,
  hilo_unit_if.slave bus
);

  localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(TIMEOUT_CYCLES);

  hilo_state_t      state_r;
  hilo_state_t      state_next_s;
  hilo_op_t         op_r;
  hilo_op_t         op_d_s;
  logic [CNT_W-1:0] cnt_r;
  logic [CNT_W-1:0] cnt_d_s;
  logic [31:0]      hi_r, lo_r, hi_d_s, lo_d_s;
  logic             mult_ctrl_r, mult_ctrl_d_s;
  logic             div_ctrl_r, div_ctrl_d_s;
  logic             busy_r;
  logic             dz_exc_r, dz_exc_d_s;
  logic             timeout_r, timeout_d_s;
  logic             madd_go_s;
  logic [63:0]      mult_result_s;
  logic             watchdog_s;

`ifdef HILO_MADD_EN
  assign madd_go_s     = bus.MaddStart;
  assign mult_result_s = (op_r == OP_MADD) ? ({hi_r, lo_r} + {bus.MultHI, bus.MultLO})
                                           : {bus.MultHI, bus.MultLO};
`else
  assign madd_go_s     = 1'b0;
  assign mult_result_s = {bus.MultHI, bus.MultLO};
`endif

  assign watchdog_s = (cnt_r == CNT_LIMIT);

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Next-state logic; only the done of the selected unit can end a wait.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      IDLE: begin
        if (bus.MultStart || madd_go_s || bus.DivStart) begin
          state_next_s = ISSUE;
        end else begin
          state_next_s = IDLE;
        end
      end
      ISSUE: begin
        if (op_r == OP_DIV) begin
          state_next_s = DIV_WAIT;
        end else begin
          state_next_s = MULT_WAIT;
        end
      end
      MULT_WAIT: begin
        if (bus.MultDone || watchdog_s) begin
          state_next_s = IDLE;
        end else begin
          state_next_s = MULT_WAIT;
        end
      end
      DIV_WAIT: begin
        if (bus.DivDone || watchdog_s) begin
          state_next_s = IDLE;
        end else begin
          state_next_s = DIV_WAIT;
        end
      end
      default: state_next_s = IDLE;
    endcase
  end

  // Output/datapath next values; the start pulse is registered so it lands in ISSUE.
  always_comb begin
    op_d_s        = op_r;
    cnt_d_s       = cnt_r;
    hi_d_s        = hi_r;
    lo_d_s        = lo_r;
    mult_ctrl_d_s = 1'b0;
    div_ctrl_d_s  = 1'b0;
    dz_exc_d_s    = 1'b0;
    timeout_d_s   = timeout_r;
    case (state_r)
      IDLE: begin
        cnt_d_s = {CNT_W{1'b0}};
        if (bus.MultStart) begin
          op_d_s        = OP_MULT;
          mult_ctrl_d_s = 1'b1;
        end else if (madd_go_s) begin
          op_d_s        = OP_MADD;
          mult_ctrl_d_s = 1'b1;
        end else if (bus.DivStart) begin
          op_d_s       = OP_DIV;
          div_ctrl_d_s = 1'b1;
        end else begin
          if (bus.MthiWr) begin
            hi_d_s = bus.RegAOut;
          end else begin
            hi_d_s = hi_r;
          end
          if (bus.MtloWr) begin
            lo_d_s = bus.RegAOut;
          end else begin
            lo_d_s = lo_r;
          end
        end
      end
      ISSUE: begin
        cnt_d_s = {CNT_W{1'b0}};
      end
      MULT_WAIT: begin
        if (bus.MultDone) begin
          {hi_d_s, lo_d_s} = mult_result_s;
        end else if (watchdog_s) begin
          timeout_d_s = 1'b1;
        end else begin
          cnt_d_s = cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
        end
      end
      DIV_WAIT: begin
        if (bus.DivDone) begin
          if (bus.DivZero) begin
            dz_exc_d_s = 1'b1;
          end else begin
            hi_d_s = bus.DivHI;
            lo_d_s = bus.DivLO;
          end
        end else if (watchdog_s) begin
          timeout_d_s = 1'b1;
        end else begin
          cnt_d_s = cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
        end
      end
      default: begin
        cnt_d_s = {CNT_W{1'b0}};
      end
    endcase
  end

  // Datapath and output registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      op_r        <= OP_MULT;
      cnt_r       <= {CNT_W{1'b0}};
      hi_r        <= 32'd0;
      lo_r        <= 32'd0;
      mult_ctrl_r <= 1'b0;
      div_ctrl_r  <= 1'b0;
      busy_r      <= 1'b0;
      dz_exc_r    <= 1'b0;
      timeout_r   <= 1'b0;
    end else begin
      op_r        <= op_d_s;
      cnt_r       <= cnt_d_s;
      hi_r        <= hi_d_s;
      lo_r        <= lo_d_s;
      mult_ctrl_r <= mult_ctrl_d_s;
      div_ctrl_r  <= div_ctrl_d_s;
      busy_r      <= (state_next_s != IDLE);
      dz_exc_r    <= dz_exc_d_s;
      timeout_r   <= timeout_d_s;
    end
  end

  assign bus.MultCtrl   = mult_ctrl_r;
  assign bus.DivCtrl    = div_ctrl_r;
  assign bus.HI         = hi_r;
  assign bus.LO         = lo_r;
  assign bus.HiLoBusy   = busy_r;
  assign bus.DivZeroExc = dz_exc_r;
  assign bus.Timeout    = timeout_r;

endmodule

// File: tb/tb_hilo_unit.sv
// Directed self-checking bench for hilo_unit; the bench itself plays the mult/div units.
module tb_hilo_unit;
  import hilo_pkg::*;

  logic clk;
  logic reset;
  int   checks;
  int   errors;
  int   pulses;
  int   busy_low;
  int   div_pulses;
  bit   seen;

  hilo_unit_if bus();

  hilo_unit #(.TIMEOUT_CYCLES(40), .CNT_W(6)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    reset  = 1'b1;
    bus.MultStart = 1'b0; bus.DivStart = 1'b0; bus.MaddStart = 1'b0;
    bus.MthiWr = 1'b0; bus.MtloWr = 1'b0; bus.RegAOut = 32'd0;
    bus.MultDone = 1'b0; bus.MultHI = 32'd0; bus.MultLO = 32'd0;
    bus.DivDone = 1'b0; bus.DivHI = 32'd0; bus.DivLO = 32'd0; bus.DivZero = 1'b0;
    step(); step();
    chk("rst_hi", bus.HI, 64'd0);
    chk("rst_lo", bus.LO, 64'd0);
    chk("rst_ctrl", {bus.MultCtrl, bus.DivCtrl, bus.HiLoBusy, bus.DivZeroExc, bus.Timeout}, 64'd0);
    reset = 1'b0;
    step();

    // MULT: done raised MULT_LATENCY cycles after the start pulse
    bus.MultStart = 1'b1;
    step();
    bus.MultStart = 1'b0;
    chk("mult_ctrl_issue", bus.MultCtrl, 64'd1);
    pulses = 0; busy_low = 0;
    for (int c = 1; c <= MULT_LATENCY; c++) begin
      if (bus.MultCtrl) pulses++;
      if (!bus.HiLoBusy) busy_low++;
      if (c == MULT_LATENCY) begin
        bus.MultDone = 1'b1; bus.MultHI = 32'hFFFFFFFF; bus.MultLO = 32'hFFFFFFFA;
      end
      step();
    end
    bus.MultDone = 1'b0;
    chk("mult_ctrl_pulses", 64'(pulses), 64'd1);
    chk("mult_busy_gaps", 64'(busy_low), 64'd0);
    chk("mult_hi", bus.HI, 64'hFFFFFFFF);
    chk("mult_lo", bus.LO, 64'hFFFFFFFA);
    chk("mult_busy_drop", bus.HiLoBusy, 64'd0);

    // DIV normal
    bus.DivStart = 1'b1;
    step();
    bus.DivStart = 1'b0;
    chk("div_ctrl_issue", {bus.MultCtrl, bus.DivCtrl}, 64'd1);
    step();
    chk("div_ctrl_single", bus.DivCtrl, 64'd0);
    bus.DivDone = 1'b1; bus.DivHI = 32'd3; bus.DivLO = 32'd7;
    step();
    bus.DivDone = 1'b0;
    chk("div_hi", bus.HI, 64'd3);
    chk("div_lo", bus.LO, 64'd7);
    chk("div_busy_drop", bus.HiLoBusy, 64'd0);

    // DIV by zero
    bus.DivStart = 1'b1;
    step();
    bus.DivStart = 1'b0;
    step();
    bus.DivDone = 1'b1; bus.DivZero = 1'b1; bus.DivHI = 32'd99; bus.DivLO = 32'd99;
    step();
    bus.DivDone = 1'b0; bus.DivZero = 1'b0;
    chk("dz_exc_high", bus.DivZeroExc, 64'd1);
    chk("dz_hilo_kept", {bus.HI, bus.LO}, {32'd3, 32'd7});
    step();
    chk("dz_exc_one_cycle", bus.DivZeroExc, 64'd0);

    // MTHI / MTLO from IDLE
    bus.MthiWr = 1'b1; bus.RegAOut = 32'hDEADBEEF;
    step();
    bus.MthiWr = 1'b0;
    chk("mthi", bus.HI, 64'hDEADBEEF);
    bus.MtloWr = 1'b1; bus.RegAOut = 32'h12345678;
    step();
    bus.MtloWr = 1'b0;
    chk("mtlo", bus.LO, 64'h12345678);
    chk("mtlo_hi_kept", bus.HI, 64'hDEADBEEF);

    // Simultaneous starts plus a write: mult wins, the write is dropped
    bus.MultStart = 1'b1; bus.DivStart = 1'b1; bus.MtloWr = 1'b1; bus.RegAOut = 32'h0000CAFE;
    step();
    bus.MultStart = 1'b0; bus.DivStart = 1'b0; bus.MtloWr = 1'b0;
    chk("prio_ctrl", {bus.MultCtrl, bus.DivCtrl}, 64'd2);
    chk("start_drops_write", bus.LO, 64'h12345678);
    div_pulses = 0;
    step();
    bus.MthiWr = 1'b1; bus.RegAOut = 32'h0BADF00D;
    step();
    bus.MthiWr = 1'b0;
    if (bus.DivCtrl) div_pulses++;
    bus.DivDone = 1'b1; bus.DivHI = 32'h55555555; bus.DivLO = 32'h55555555;
    step();
    bus.DivDone = 1'b0;
    if (bus.DivCtrl) div_pulses++;
    chk("busy_write_ignored", bus.HI, 64'hDEADBEEF);
    chk("spurious_divdone", {bus.HiLoBusy, bus.LO}, {32'd1, 32'h12345678});
    bus.MultDone = 1'b1; bus.MultHI = 32'h11111111; bus.MultLO = 32'h22222222;
    step();
    bus.MultDone = 1'b0;
    chk("no_div_ctrl", 64'(div_pulses), 64'd0);
    chk("mult2_commit", {bus.HI, bus.LO}, {32'h11111111, 32'h22222222});

    // Watchdog: no done ever returned
    bus.MultStart = 1'b1;
    step();
    bus.MultStart = 1'b0;
    for (int c = 1; c < 40; c++) step();
    chk("timeout_not_early", {bus.Timeout, bus.HiLoBusy}, 64'd1);
    seen = 1'b0;
    for (int c = 0; c < 30; c++) begin
      if (bus.Timeout) begin
        seen = 1'b1;
        break;
      end
      step();
    end
    chk("timeout_set", 64'(seen), 64'd1);
    chk("timeout_idle", bus.HiLoBusy, 64'd0);
    chk("timeout_hilo_kept", {bus.HI, bus.LO}, {32'h11111111, 32'h22222222});
    step(); step();
    chk("timeout_sticky", bus.Timeout, 64'd1);

    // Asynchronous reset in the middle of MULT_WAIT
    bus.MultStart = 1'b1;
    step();
    bus.MultStart = 1'b0;
    for (int c = 0; c < 5; c++) step();
    #2 reset = 1'b1;
    #1;
    chk("async_rst_hilo", {bus.HI, bus.LO}, 64'd0);
    chk("async_rst_flags", {bus.MultCtrl, bus.DivCtrl, bus.HiLoBusy, bus.DivZeroExc, bus.Timeout}, 64'd0);
    step();
    reset = 1'b0;
    step();

`ifdef HILO_MADD_EN
    bus.MtloWr = 1'b1; bus.RegAOut = 32'hFFFFFFFF;
    step();
    bus.MtloWr = 1'b0;
    bus.MaddStart = 1'b1;
    step();
    bus.MaddStart = 1'b0;
    chk("madd_ctrl", bus.MultCtrl, 64'd1);
    step();
    bus.MultDone = 1'b1; bus.MultHI = 32'd0; bus.MultLO = 32'd1;
    step();
    bus.MultDone = 1'b0;
    chk("madd_sum", {bus.HI, bus.LO}, {32'd1, 32'd0});
`else
    bus.MaddStart = 1'b1;
    step();
    bus.MaddStart = 1'b0;
    chk("madd_ignored", {bus.MultCtrl, bus.HiLoBusy}, 64'd0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
